// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_reg family: width math for the occupancy counter.
package pipe_pkg;

    localparam int DEPTH_MIN = 1;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2_f(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n)) w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a counter that must reach depth inclusive.
    function automatic int occ_w_f(input int depth);
        return clog2_f(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_asyn_ah.sv
// One delay-line stage: {valid, data} flop with async active-high reset, sync clear and enable.
module pipe_stage_asyn_ah #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sclr,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= {1'b0, RESET_VAL};
        else if (sclr) q <= {1'b0, RESET_VAL};
        else if (en)   q <= d;
    end

endmodule

// File: rtl/pipe_reg_asyn_ah.sv
// Parametrised retiming delay line with per-stage valid, enable, sync clear and occupancy count.
module pipe_reg_asyn_ah
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset_ah_in,
    input  logic                        en_in,
    input  logic                        sclr_in,
    input  logic                        valid_in,
    input  logic [WIDTH-1:0]            d_in,
    output logic [WIDTH-1:0]            q_out,
    output logic                        valid_out,
    output logic [occ_w_f(DEPTH)-1:0]   occ_out
);

    localparam int OCC_W = occ_w_f(DEPTH);

    if (DEPTH < DEPTH_MIN) begin : g_bad_depth
        $error("pipe_reg_asyn_ah: DEPTH must be at least 1");
    end

    // Bit WIDTH of each stage is its valid flag.
    logic [DEPTH-1:0][WIDTH:0] stage_q;
    logic [DEPTH-1:0][WIDTH:0] stage_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[i] = {valid_in, d_in};
        end else begin : g_body
            assign stage_d[i] = stage_q[i-1];
        end

        pipe_stage_asyn_ah #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk  (clk),
            .rst  (reset_ah_in),
            .en   (en_in),
            .sclr (sclr_in),
            .d    (stage_d[i]),
            .q    (stage_q[i])
        );
    end

    assign q_out     = stage_q[DEPTH-1][WIDTH-1:0];
    assign valid_out = stage_q[DEPTH-1][WIDTH];

    // Incremental popcount: one valid enters, the last stage's valid leaves.
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            occ_q <= '0;
        end else if (sclr_in) begin
            occ_q <= '0;
        end else if (en_in) begin
            if (valid_in && !valid_out)      occ_q <= occ_q + OCC_W'(1);
            else if (!valid_in && valid_out) occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occ_out = occ_q;

endmodule

// File: tb/tb_pipe_reg_asyn_ah.sv
// Directed bench: a DEPTH=4 delay line driven from a vector table plus hand sequences,
// and a DEPTH=1 instance with a non-zero reset value.
module tb_pipe_reg_asyn_ah;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=4, WIDTH=8, RESET_VAL=0
    logic       en, sclr, vin;
    logic [7:0] d;
    logic [7:0] q;
    logic       vout;
    logic [2:0] occ;

    pipe_reg_asyn_ah #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
        .clk         (clk),
        .reset_ah_in (rst),
        .en_in       (en),
        .sclr_in     (sclr),
        .valid_in    (vin),
        .d_in        (d),
        .q_out       (q),
        .valid_out   (vout),
        .occ_out     (occ)
    );

    // DEPTH=1, RESET_VAL=0xFF
    logic       en1, sclr1, vin1;
    logic [7:0] d1;
    logic [7:0] q1;
    logic       vout1;
    logic [0:0] occ1;

    pipe_reg_asyn_ah #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hFF)) u_dut1 (
        .clk         (clk),
        .reset_ah_in (rst),
        .en_in       (en1),
        .sclr_in     (sclr1),
        .valid_in    (vin1),
        .d_in        (d1),
        .q_out       (q1),
        .valid_out   (vout1),
        .occ_out     (occ1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       en;
        logic       sclr;
        logic       vin;
        logic [7:0] d;
        logic [7:0] q;
        logic       v;
        logic [2:0] occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic s, input logic vi, input logic [7:0] dd,
                                input logic [7:0] qq, input logic vv, input logic [2:0] oo);
        vec_t t;
        t.en = e; t.sclr = s; t.vin = vi; t.d = dd; t.q = qq; t.v = vv; t.occ = oo;
        return t;
    endfunction

    // Drive 4-deep inputs, take one edge, check outputs just after it.
    task automatic step4(input logic e, input logic s, input logic vi, input logic [7:0] dd,
                         input logic [7:0] qq, input logic vv, input logic [2:0] oo, input string tag);
        en = e; sclr = s; vin = vi; d = dd;
        @(posedge clk); #1;
        chk({tag, ".q"},   32'(q),    32'(qq));
        chk({tag, ".v"},   32'(vout), 32'(vv));
        chk({tag, ".occ"}, 32'(occ),  32'(oo));
    endtask

    task automatic step1(input logic e, input logic s, input logic vi, input logic [7:0] dd,
                         input logic [7:0] qq, input logic vv, input logic oo, input string tag);
        en1 = e; sclr1 = s; vin1 = vi; d1 = dd;
        @(posedge clk); #1;
        chk({tag, ".q"},   32'(q1),    32'(qq));
        chk({tag, ".v"},   32'(vout1), 32'(vv));
        chk({tag, ".occ"}, 32'(occ1),  32'(oo));
    endtask

    initial begin
        // fill: en, sclr, vin, d  ->  q, valid, occ
        vecs.push_back(mk(1, 0, 1, 8'h11, 8'h00, 0, 3'd1));
        vecs.push_back(mk(1, 0, 1, 8'h22, 8'h00, 0, 3'd2));
        vecs.push_back(mk(1, 0, 1, 8'h33, 8'h00, 0, 3'd3));
        vecs.push_back(mk(1, 0, 1, 8'h44, 8'h11, 1, 3'd4));
        vecs.push_back(mk(1, 0, 1, 8'h55, 8'h22, 1, 3'd4));
        vecs.push_back(mk(1, 0, 1, 8'h66, 8'h33, 1, 3'd4));
        // alternating valid, d = 1..8
        vecs.push_back(mk(1, 0, 1, 8'h01, 8'h44, 1, 3'd4));
        vecs.push_back(mk(1, 0, 0, 8'h02, 8'h55, 1, 3'd3));
        vecs.push_back(mk(1, 0, 1, 8'h03, 8'h66, 1, 3'd3));
        vecs.push_back(mk(1, 0, 0, 8'h04, 8'h01, 1, 3'd2));
        vecs.push_back(mk(1, 0, 1, 8'h05, 8'h02, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 8'h06, 8'h03, 1, 3'd2));
        vecs.push_back(mk(1, 0, 1, 8'h07, 8'h04, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 8'h08, 8'h05, 1, 3'd2));
        // refill to full
        vecs.push_back(mk(1, 0, 1, 8'hD1, 8'h06, 0, 3'd2));
        vecs.push_back(mk(1, 0, 1, 8'hD2, 8'h07, 1, 3'd3));
        vecs.push_back(mk(1, 0, 1, 8'hD3, 8'h08, 0, 3'd3));
        vecs.push_back(mk(1, 0, 1, 8'hD4, 8'hD1, 1, 3'd4));
        // sclr beats en; input discarded
        vecs.push_back(mk(1, 1, 1, 8'hEE, 8'h00, 0, 3'd0));
        // 0xA5 with three disabled cycles in the middle
        vecs.push_back(mk(1, 0, 1, 8'hA5, 8'h00, 0, 3'd1));
        vecs.push_back(mk(0, 0, 1, 8'hBB, 8'h00, 0, 3'd1));
        vecs.push_back(mk(0, 0, 1, 8'hBC, 8'h00, 0, 3'd1));
        vecs.push_back(mk(0, 0, 1, 8'hBD, 8'h00, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 8'hC0, 8'h00, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 8'hC1, 8'h00, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 8'hC2, 8'hA5, 1, 3'd1));
        vecs.push_back(mk(1, 0, 0, 8'hC3, 8'hC0, 0, 3'd0));

        rst = 1'b1;
        en = 0; sclr = 0; vin = 0; d = '0;
        en1 = 0; sclr1 = 0; vin1 = 0; d1 = '0;
        #1;
        chk("rst.q",    32'(q),     32'h00);
        chk("rst.v",    32'(vout),  32'h0);
        chk("rst.occ",  32'(occ),   32'h0);
        chk("rst1.q",   32'(q1),    32'hFF);
        chk("rst1.v",   32'(vout1), 32'h0);
        chk("rst1.occ", 32'(occ1),  32'h0);
        #12 rst = 1'b0;

        foreach (vecs[i]) begin
            step4(vecs[i].en, vecs[i].sclr, vecs[i].vin, vecs[i].d,
                  vecs[i].q, vecs[i].v, vecs[i].occ, $sformatf("vec%0d", i));
        end

        // Async reset mid-cycle while full, then refill.
        step4(1, 0, 1, 8'hF1, 8'hC1, 0, 3'd1, "fill1");
        step4(1, 0, 1, 8'hF2, 8'hC2, 0, 3'd2, "fill2");
        step4(1, 0, 1, 8'hF3, 8'hC3, 0, 3'd3, "fill3");
        step4(1, 0, 1, 8'hF4, 8'hF1, 1, 3'd4, "fill4");
        #2 rst = 1'b1;
        #1;
        chk("arst.q",   32'(q),    32'h00);
        chk("arst.v",   32'(vout), 32'h0);
        chk("arst.occ", 32'(occ),  32'h0);
        @(posedge clk); #1;
        chk("arst_hold.q",   32'(q),    32'h00);
        chk("arst_hold.occ", 32'(occ),  32'h0);
        rst = 1'b0;
        step4(1, 0, 1, 8'h5A, 8'h00, 0, 3'd1, "refill1");
        step4(1, 0, 1, 8'h5B, 8'h00, 0, 3'd2, "refill2");
        step4(1, 0, 1, 8'h5C, 8'h00, 0, 3'd3, "refill3");
        step4(1, 0, 1, 8'h5D, 8'h5A, 1, 3'd4, "refill4");
        en = 0;

        // DEPTH=1 with RESET_VAL=0xFF
        step1(1, 0, 1, 8'h3C, 8'h3C, 1, 1'b1, "d1.load");
        step1(0, 0, 0, 8'h99, 8'h3C, 1, 1'b1, "d1.hold");
        step1(1, 0, 0, 8'h3D, 8'h3D, 0, 1'b0, "d1.inval");
        step1(1, 0, 1, 8'h3E, 8'h3E, 1, 1'b1, "d1.reload");
        step1(1, 0, 1, 8'h3F, 8'h3F, 1, 1'b1, "d1.full");
        step1(1, 1, 1, 8'h40, 8'hFF, 0, 1'b0, "d1.sclr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
